// File: rtl/triangle_fifo_arbiter_pkg.sv
// Shared types and constants for the triangle FIFO write arbiter.
// Channel-index and beat-counter widths are derived here.
package triangle_fifo_pkg;

    localparam int DATA_W_DEF = 224;
    localparam int MAX_CH     = 8;
    // PACKET_LEN tops out at 15, so four bits always hold the beat count.
    localparam int BEAT_W     = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/triangle_fifo_arbiter_if.sv
// Producer-side and FIFO-side signal bundle of the triangle FIFO arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface triangle_fifo_arbiter_if #(
    parameter int DATA_W = 224,
    parameter int NUM_CH = 2
);
    logic                     nextFrame;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_push;
    logic [NUM_CH-1:0]        in_wait;
    logic [DATA_W-1:0]        TriangleFIFO_WriteData;
    logic                     TriangleFIFO_push;
    logic                     TriangleFIFO_full;
    logic                     TriangleFIFO_prog_full;
    logic [NUM_CH-1:0]        overflow;
    logic                     busy;

    modport slave (
        input  nextFrame, in_data, in_push, TriangleFIFO_full, TriangleFIFO_prog_full,
        output in_wait, TriangleFIFO_WriteData, TriangleFIFO_push, overflow, busy
    );

    modport master (
        output nextFrame, in_data, in_push, TriangleFIFO_full, TriangleFIFO_prog_full,
        input  in_wait, TriangleFIFO_WriteData, TriangleFIFO_push, overflow, busy
    );

endinterface

// File: rtl/triangle_fifo_arbiter_buf.sv
// Per-channel skid buffer: small synchronous FIFO with first-word fall-through
// read so a pop and its data land in the same cycle.
module tri_chan_buf #(
    parameter  int DATA_W = 224,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              wr_en;
    logic              rd_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign wr_en = push_i && !flush_i && (!full_o || pop_i);
    assign rd_en = pop_i && !flush_i && !empty_o;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/triangle_fifo_arbiter.sv
// N-channel packet-atomic write arbiter in front of the shared triangle FIFO.
// Per-channel skid buffers, fixed-priority or round-robin grant, registered output.
module triangle_fifo_arbiter
    import triangle_fifo_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_CH     = 2,
    parameter int BUF_DEPTH  = 4,
    parameter int PACKET_LEN = 2,
    parameter int RR_MODE    = 1
) (
    input logic                   clk100,
    input logic                   reset,
    triangle_fifo_arbiter_if.slave bus
);

    localparam int CH_W  = ch_idx_w(NUM_CH);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PACKET_LEN);
    localparam logic [CNT_W-1:0]  WAIT_LVL  = CNT_W'(BUF_DEPTH - 1);

    logic [DATA_W-1:0] buf_rdata [NUM_CH];
    logic [CNT_W-1:0]  buf_count [NUM_CH];
    logic [NUM_CH-1:0] buf_full;
    logic [NUM_CH-1:0] buf_empty;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] wait_vec;
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] ovf_q;

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              grant_vld;
    logic [CH_W-1:0]   grant_ch;
    logic [CH_W-1:0]   win_ch;
    logic              win_vld;
    logic              push_q;
    logic [DATA_W-1:0] data_q;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            tri_chan_buf #(
                .DATA_W (DATA_W),
                .DEPTH  (BUF_DEPTH)
            ) u_buf (
                .clk     (clk100),
                .rst     (reset),
                .flush_i (bus.nextFrame),
                .push_i  (bus.in_push[gi]),
                .pop_i   (pop[gi]),
                .wdata_i (bus.in_data[gi*DATA_W +: DATA_W]),
                .rdata_o (buf_rdata[gi]),
                .count_o (buf_count[gi]),
                .full_o  (buf_full[gi]),
                .empty_o (buf_empty[gi])
            );

            assign wait_vec[gi] = (buf_count[gi] >= WAIT_LVL) || bus.TriangleFIFO_prog_full;
            assign ovf_set[gi]  = bus.in_push[gi] && buf_full[gi] && !pop[gi];
        end
    endgenerate

    // Scan starts at the RR pointer in round-robin mode, at channel 0 otherwise.
    function automatic logic [CH_W-1:0] first_ready(input logic [NUM_CH-1:0] ready,
                                                    input logic [CH_W-1:0]   start);
        logic [CH_W-1:0] sel;
        logic            found;
        int              idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(start) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && ready[idx[CH_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[CH_W-1:0];
            end
        end
        return sel;
    endfunction

    assign win_vld = |(~buf_empty);
    assign win_ch  = first_ready(~buf_empty, (RR_MODE != 0) ? rr_ptr_q : '0);

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        beats_d   = beats_q;
        rr_ptr_d  = rr_ptr_q;
        grant_vld = 1'b0;
        grant_ch  = lock_ch_q;
        pop       = '0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.TriangleFIFO_full && win_vld) begin
                    grant_vld = 1'b1;
                    grant_ch  = win_ch;
                    rr_ptr_d  = (win_ch == CH_W'(NUM_CH - 1)) ? '0 : win_ch + CH_W'(1);
                    if (PACKET_LEN > 1) begin
                        state_d   = ST_LOCKED;
                        lock_ch_d = win_ch;
                        beats_d   = BEAT_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (!bus.TriangleFIFO_full && !buf_empty[lock_ch_q]) begin
                    grant_vld = 1'b1;
                    beats_d   = beats_q + BEAT_W'(1);
                    if (beats_q + BEAT_W'(1) == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (grant_vld) pop[grant_ch] = 1'b1;
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lock_ch_q <= '0;
            beats_q   <= '0;
            rr_ptr_q  <= '0;
            push_q    <= 1'b0;
            data_q    <= '0;
            ovf_q     <= '0;
        end else if (bus.nextFrame) begin
            state_q   <= ST_IDLE;
            lock_ch_q <= '0;
            beats_q   <= '0;
            rr_ptr_q  <= '0;
            push_q    <= 1'b0;
            data_q    <= '0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            beats_q   <= beats_d;
            rr_ptr_q  <= rr_ptr_d;
            push_q    <= grant_vld;
            data_q    <= grant_vld ? buf_rdata[grant_ch] : '0;
            ovf_q     <= ovf_q | ovf_set;
        end
    end

    assign bus.in_wait                = wait_vec;
    assign bus.overflow               = ovf_q;
    assign bus.TriangleFIFO_push      = push_q;
    assign bus.TriangleFIFO_WriteData = data_q;
    assign bus.busy                   = win_vld || (state_q == ST_LOCKED);

endmodule

// File: tb/tb_triangle_fifo_arbiter.sv
// Three arbiter variants (PL=2 fixed, PL=2 round-robin, PL=1 fixed) share one
// stimulus stream and are compared against a queue-based packet model.
module tb_triangle_fifo_arbiter;

    localparam int DW = 224;
    localparam int NC = 2;
    localparam int NI = 3;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           next_frame = 1'b0;
    logic           full = 1'b0;
    logic           pfull = 1'b0;
    logic [NC*DW-1:0] in_data = '0;
    logic [NC-1:0]  in_push = '0;

    logic           obs_push [NI];
    logic [DW-1:0]  obs_data [NI];
    logic [NC-1:0]  obs_wait [NI];
    logic [NC-1:0]  obs_ovf  [NI];
    logic           obs_busy [NI];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one queue per instance/channel plus packet lock state.
    logic [DW-1:0] mq [NI*NC][$];
    int            lk    [NI];
    int            beats [NI];
    int            ptr   [NI];
    logic [NC-1:0] m_ovf [NI];
    logic          m_push[NI];
    logic [DW-1:0] m_data[NI];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            triangle_fifo_arbiter_if #(.DATA_W(DW), .NUM_CH(NC)) bus ();
            assign bus.nextFrame              = next_frame;
            assign bus.in_data                = in_data;
            assign bus.in_push                = in_push;
            assign bus.TriangleFIFO_full      = full;
            assign bus.TriangleFIFO_prog_full = pfull;
            assign obs_push[gi] = bus.TriangleFIFO_push;
            assign obs_data[gi] = bus.TriangleFIFO_WriteData;
            assign obs_wait[gi] = bus.in_wait;
            assign obs_ovf[gi]  = bus.overflow;
            assign obs_busy[gi] = bus.busy;

            triangle_fifo_arbiter #(
                .DATA_W     (DW),
                .NUM_CH     (NC),
                .BUF_DEPTH  (DEPTH),
                .PACKET_LEN ((gi == 2) ? 1 : 2),
                .RR_MODE    ((gi == 1) ? 1 : 0)
            ) u_dut (
                .clk100 (clk),
                .reset  (rst),
                .bus    (bus.slave)
            );
        end
    endgenerate

    function automatic logic [DW-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input int k, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < NC; c++) mq[k*NC+c].delete();
            lk[k]     = -1;
            beats[k]  = 0;
            ptr[k]    = 0;
            m_ovf[k]  = '0;
            m_push[k] = 1'b0;
            m_data[k] = '0;
        end
    endtask

    task automatic model_step();
        if (next_frame) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NI; k++) begin
            int pl;
            int pc;
            pl = (k == 2) ? 1 : 2;
            pc = -1;
            if (!full) begin
                if (lk[k] >= 0) begin
                    if (mq[k*NC+lk[k]].size() > 0) pc = lk[k];
                end else begin
                    for (int o = 0; o < NC; o++) begin
                        int c;
                        c = (k == 1) ? (ptr[k] + o) % NC : o;
                        if (pc < 0 && mq[k*NC+c].size() > 0) pc = c;
                    end
                end
            end
            if (pc >= 0) begin
                m_push[k] = 1'b1;
                m_data[k] = mq[k*NC+pc].pop_front();
                if (lk[k] < 0) begin
                    ptr[k] = (pc + 1) % NC;
                    if (pl > 1) begin
                        lk[k]    = pc;
                        beats[k] = 1;
                    end
                end else begin
                    beats[k]++;
                    if (beats[k] == pl) lk[k] = -1;
                end
            end else begin
                m_push[k] = 1'b0;
                m_data[k] = '0;
            end
            for (int c = 0; c < NC; c++) begin
                if (in_push[c]) begin
                    if (mq[k*NC+c].size() >= DEPTH) m_ovf[k][c] = 1'b1;
                    else mq[k*NC+c].push_back(in_data[c*DW +: DW]);
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            logic [NC-1:0] ew;
            logic          eb;
            eb = (lk[k] >= 0);
            for (int c = 0; c < NC; c++) begin
                ew[c] = (mq[k*NC+c].size() >= DEPTH - 1) || pfull;
                if (mq[k*NC+c].size() > 0) eb = 1'b1;
            end
            chk("push", k, DW'(obs_push[k]), DW'(m_push[k]));
            chk("data", k, obs_data[k], m_data[k]);
            chk("in_wait", k, DW'(obs_wait[k]), DW'(ew));
            chk("overflow", k, DW'(obs_ovf[k]), DW'(m_ovf[k]));
            chk("busy", k, DW'(obs_busy[k]), DW'(eb));
        end
    endtask

    task automatic cycle();
        #1 check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [NC-1:0] p, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        in_push = p;
        in_data = {d1, d0};
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, '0);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #2 check_all();
        @(negedge clk);
        rst = 1'b0;

        // Single A5 record on ch0
        drive(2'b01, {28{8'hA5}}, '0);
        idle(5);

        // Simultaneous packets on both channels
        drive(2'b11, rnd(), rnd());
        drive(2'b11, rnd(), rnd());
        idle(7);

        // Interleaved: A0, B0, gap, A1
        drive(2'b01, rnd(), '0);
        drive(2'b10, '0, rnd());
        idle(3);
        drive(2'b01, rnd(), '0);
        idle(6);

        // FIFO full for 10 cycles while ch1 overfills
        full = 1'b1;
        for (int i = 0; i < 10; i++) drive((i < 5) ? 2'b10 : 2'b00, '0, rnd());
        full = 1'b0;
        idle(8);

        // prog_full alone: back-pressure asserted, draining continues
        pfull = 1'b1;
        drive(2'b11, rnd(), rnd());
        drive(2'b11, rnd(), rnd());
        idle(5);
        pfull = 1'b0;

        // nextFrame while locked on ch0 with records pending
        full = 1'b1;
        for (int i = 0; i < 3; i++) drive(2'b01, rnd(), '0);
        full = 1'b0;
        idle(1);
        next_frame = 1'b1;
        drive(2'b11, rnd(), rnd());
        next_frame = 1'b0;
        idle(1);
        drive(2'b01, rnd(), '0);
        idle(5);

        // Asynchronous reset in the middle of a cycle with output active
        drive(2'b11, rnd(), rnd());
        drive(2'b11, rnd(), rnd());
        in_push = '0;
        #1 check_all();
        @(posedge clk);
        model_step();
        #3 rst = 1'b1;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        drive(2'b10, '0, rnd());
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            full       = ($urandom_range(3) == 0);
            pfull      = ($urandom_range(7) == 0);
            next_frame = ($urandom_range(63) == 0);
            drive(NC'($urandom_range(3)), rnd(), rnd());
        end
        full = 1'b0;
        pfull = 1'b0;
        next_frame = 1'b0;
        idle(12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
